i2c_reg_master: RTL
===================

# i2c_reg_master

Single-transaction I2C register master for sensor access on the avionics board. It runs directly from the 100 kHz divided clock and splits each I2C bit into four quarter-phases, so SCL is 25 kHz. Per request it performs one register write or one register read on an attached sensor. It is the consumer of the 1 MHz→100 kHz clock stage and is the sole master on its I2C bus.

## Interface
Parameters:
- none (timing is fixed by the 100 kHz input and 4 quarter-phases per bit)

Ports:
- CLK_100KHZ_IN  in  1  sole clock, 100 kHz
- RESET_N_IN  in  1  asynchronous, active-low reset
- START_IN  in  1  request; sampled high in IDLE to begin a transaction
- RW_IN  in  1  0 = register write, 1 = register read
- DEV_ADDR_IN  in  7  7-bit slave address
- REG_ADDR_IN  in  8  register address
- WDATA_IN  in  8  write data, ignored on reads
- RDATA_OUT  out  8  read data; valid from DONE_OUT until the next accepted START
- BUSY_OUT  out  1  high while a transaction is in progress
- DONE_OUT  out  1  one-cycle pulse at end of transaction
- ACK_ERR_OUT  out  1  a slave NACK occurred; held until the next accepted START
- SCL_OUT  out  1  push-pull SCL; no clock stretching
- SDA_OE_OUT  out  1  1 = pull SDA low, 0 = release
- SDA_IN  in  1  sampled SDA line

## Operation
- Reset values: SCL_OUT=1, SDA_OE_OUT=0, BUSY_OUT=0, DONE_OUT=0, ACK_ERR_OUT=0, RDATA_OUT=0x00, state IDLE.
- In IDLE with START_IN=1 at an edge:
  - latch RW_IN, DEV_ADDR_IN, REG_ADDR_IN and WDATA_IN;
  - clear ACK_ERR_OUT;
  - set BUSY_OUT;
  - enter START.
- START_IN is ignored while BUSY_OUT=1.
- States: IDLE, START, ADDR_W, ACK_A, REG, ACK_R, then:
  - write path: WDATA, ACK_D, STOP;
  - read path: RSTART, ADDR_R, ACK_A2, RDATA, MNACK, STOP.
  - STOP is always followed by IDLE.
- Data bits and ack slots:
  - Bytes are sent MSB first. The address byte is {DEV_ADDR,0} in ADDR_W and {DEV_ADDR,1} in ADDR_R.
  - Each byte is 8 bit slots followed by 1 ack slot. In an ack slot SDA is released and sampled.
  - In RDATA, SDA is released and sampled each slot, shifting MSB first into RDATA_OUT. RDATA_OUT updates only when the byte completes.
  - In MNACK the master releases SDA, so the slave sees a 1 (NACK).
- NACK: a sampled SDA=1 in any ack slot sets ACK_ERR_OUT, skips the rest of the sequence and goes straight to STOP. RDATA_OUT is not updated.

## Timing
- Slot = 4 cycles, q0..q3.
- Data/ack slot:
  - q0: SCL=0, SDA updated
  - q1: SCL=1
  - q2: SCL=1, SDA sampled at the end of q2
  - q3: SCL=0
- START slot (SDA, SCL per phase): q0 = 1,1; q1 = 1,1; q2 = 0,1; q3 = 0,0.
- RSTART slot: q0 = 1,0; q1 = 1,1; q2 = 0,1; q3 = 0,0.
- STOP slot: q0 = 0,0; q1 = 0,1; q2 = 1,1; q3 = 1,1.
- SDA only changes while SCL=0, except inside the START, RSTART and STOP conditions.
- The edge that samples START_IN is cycle 0. The START slot occupies cycles 1–4.
- Write: 29 slots = 116 cycles. DONE_OUT is high in cycle 117.
- Read: 39 slots = 156 cycles. DONE_OUT is high in cycle 157.
- BUSY_OUT falls in the same cycle DONE_OUT rises. A new START_IN can be accepted on the DONE_OUT cycle's closing edge.
- Reset mid-transaction: all outputs immediately return to their reset values (SCL=1, SDA released), with no STOP generated. Bus recovery is the responsibility of higher-level logic.

## Structure
- Shared package `i2c_pkg` holds:
  - the state enum;
  - QPHASES=4;
  - RW_WRITE=0 and RW_READ=1;
  - the slot-count constants WR_SLOTS=29 and RD_SLOTS=39.
- One sub-module: `i2c_phase_gen`, a 2-bit quarter-phase counter plus a 4-bit bit-in-byte counter (0..8, where 8 is the ack slot). It outputs slot_end and byte_end strobes.
- The top module holds the state machine, shift registers and SDA/SCL output decode.

## Test plan
- Write, all ACKs: dev 0x68, reg 0x6B, data 0x00 → SDA bytes 0xD0, 0x6B, 0x00; DONE_OUT in cycle 117; ACK_ERR_OUT=0.
- Read: dev 0x76, reg 0xD0, slave returns 0x58 → bytes 0xEC, 0xD0, then RSTART and 0xED; master NACK; RDATA_OUT=0x58; DONE_OUT in cycle 157.
- Address NACK: no slave at 0x50 → START, 9 slots, STOP (11 slots); DONE_OUT in cycle 45; ACK_ERR_OUT=1; RDATA_OUT unchanged.
- START_IN pulsed at cycle 40 of a write → ignored; exactly one DONE_OUT, in cycle 117.
- Reset asserted at cycle 60 of a read → SCL_OUT=1, SDA_OE_OUT=0, BUSY_OUT=0 immediately. After release, a new write completes normally.
- Protocol monitor over all of the above → no SDA transition while SCL=1 outside START/RSTART/STOP.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C register master.
//   i2c_state_e : transaction state machine encoding
//   QPHASES     : quarter-phases per I2C bit slot
//   RW_WRITE/RW_READ : request direction and R/W bit of the address byte
//   WR_SLOTS/RD_SLOTS : bit slots in a complete write / read transaction
package i2c_pkg;

  localparam int   QPHASES  = 4;
  localparam logic RW_WRITE = 1'b0;
  localparam logic RW_READ  = 1'b1;
  localparam int   WR_SLOTS = 29;
  localparam int   RD_SLOTS = 39;

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_START  = 4'd1,
    S_ADDR_W = 4'd2,
    S_ACK_A  = 4'd3,
    S_REG    = 4'd4,
    S_ACK_R  = 4'd5,
    S_WDATA  = 4'd6,
    S_ACK_D  = 4'd7,
    S_RSTART = 4'd8,
    S_ADDR_R = 4'd9,
    S_ACK_A2 = 4'd10,
    S_RDATA  = 4'd11,
    S_MNACK  = 4'd12,
    S_STOP   = 4'd13
  } i2c_state_e;

endpackage

// File: rtl/i2c_phase_gen.sv
// Quarter-phase and bit-in-byte timing for the I2C master.
//   clk, rst_n : 100 kHz clock, asynchronous active-low reset
//   en         : high while a transaction is running; low holds phase at q0
//   bit_clr    : hold the bit counter at 0 (single-slot states)
//   phase      : current quarter-phase q0..q3
//   bit_cnt    : slot within the byte, 0..7 data, 8 = ack slot
//   slot_end   : last cycle of the current slot
//   byte_end   : last cycle of the ack slot
module i2c_phase_gen
  import i2c_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       bit_clr,
  output logic [1:0] phase,
  output logic [3:0] bit_cnt,
  output logic       slot_end,
  output logic       byte_end
);

  assign slot_end = en && (phase == 2'(QPHASES - 1));
  assign byte_end = slot_end && (bit_cnt == 4'd8);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase   <= 2'd0;
      bit_cnt <= 4'd0;
    end else begin
      if (!en) phase <= 2'd0;
      else     phase <= phase + 2'd1;

      if (!en || bit_clr)  bit_cnt <= 4'd0;
      else if (slot_end)   bit_cnt <= (bit_cnt == 4'd8) ? 4'd0 : bit_cnt + 4'd1;
    end
  end

endmodule

// File: rtl/i2c_reg_master.sv
// Single-transaction I2C register master (one register write or read).
// Each I2C bit is one slot of four 100 kHz cycles, giving SCL = 25 kHz.
//   CLK_100KHZ_IN, RESET_N_IN : clock and asynchronous active-low reset
//   START_IN, RW_IN           : request and direction (0 write, 1 read)
//   DEV_ADDR_IN, REG_ADDR_IN, WDATA_IN : transaction parameters
//   RDATA_OUT   : read byte, valid from DONE_OUT until the next accepted start
//   BUSY_OUT    : transaction in progress
//   DONE_OUT    : one-cycle completion pulse
//   ACK_ERR_OUT : slave NACK seen, held until the next accepted start
//   SCL_OUT     : push-pull SCL
//   SDA_OE_OUT  : 1 pulls SDA low, 0 releases it
//   SDA_IN      : sampled SDA line
//   STATE_DBG_OUT : current state machine state
// Request handshake: START_IN is the valid, ~BUSY_OUT is the ready; a request
// is accepted on a clock edge where both are high, and START_IN is ignored
// otherwise.
module i2c_reg_master
  import i2c_pkg::*;
(
  input  logic       CLK_100KHZ_IN,
  input  logic       RESET_N_IN,
  input  logic       START_IN,
  input  logic       RW_IN,
  input  logic [6:0] DEV_ADDR_IN,
  input  logic [7:0] REG_ADDR_IN,
  input  logic [7:0] WDATA_IN,
  output logic [7:0] RDATA_OUT,
  output logic       BUSY_OUT,
  output logic       DONE_OUT,
  output logic       ACK_ERR_OUT,
  output logic       SCL_OUT,
  output logic       SDA_OE_OUT,
  input  logic       SDA_IN,
  output logic [3:0] STATE_DBG_OUT
);

  i2c_state_e state, state_n;

  logic       rw_q;
  logic [6:0] dev_q;
  logic [7:0] reg_q;
  logic [7:0] wdata_q;
  logic [7:0] rx_shift;
  logic       sda_smp;

  logic [1:0] phase;
  logic [3:0] bit_cnt;
  logic       slot_end;
  logic       byte_end;
  logic       run;
  logic       bit_clr;
  logic       sample_now;
  logic       in_ack;
  logic       last_bit;
  logic       mid_phase;
  logic [7:0] tx_byte;
  logic       tx_bit;
  logic       scl_lvl;
  logic       sda_lvl;

  assign run        = (state != S_IDLE);
  assign bit_clr    = (state == S_IDLE) || (state == S_START) ||
                      (state == S_RSTART) || (state == S_STOP);
  assign sample_now = run && (phase == 2'd2);
  assign last_bit   = slot_end && (bit_cnt == 4'd7);
  assign mid_phase  = (phase == 2'd1) || (phase == 2'd2);
  assign in_ack     = (state == S_ACK_A) || (state == S_ACK_R) ||
                      (state == S_ACK_D) || (state == S_ACK_A2);

  assign BUSY_OUT      = run;
  assign STATE_DBG_OUT = state;

  i2c_phase_gen u_phase (
    .clk      (CLK_100KHZ_IN),
    .rst_n    (RESET_N_IN),
    .en       (run),
    .bit_clr  (bit_clr),
    .phase    (phase),
    .bit_cnt  (bit_cnt),
    .slot_end (slot_end),
    .byte_end (byte_end)
  );

  always_ff @(posedge CLK_100KHZ_IN or negedge RESET_N_IN) begin
    if (!RESET_N_IN) state <= S_IDLE;
    else             state <= state_n;
  end

  // sda_smp holds the ack bit captured at the end of q2, so the decision to
  // abort is made at the ack slot's end without a combinational SDA path.
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:   if (START_IN) state_n = S_START;
      S_START:  if (slot_end) state_n = S_ADDR_W;
      S_ADDR_W: if (last_bit) state_n = S_ACK_A;
      S_ACK_A:  if (byte_end) state_n = sda_smp ? S_STOP : S_REG;
      S_REG:    if (last_bit) state_n = S_ACK_R;
      S_ACK_R:  if (byte_end) state_n = sda_smp ? S_STOP :
                                        (rw_q == RW_READ) ? S_RSTART : S_WDATA;
      S_WDATA:  if (last_bit) state_n = S_ACK_D;
      S_ACK_D:  if (byte_end) state_n = S_STOP;
      S_RSTART: if (slot_end) state_n = S_ADDR_R;
      S_ADDR_R: if (last_bit) state_n = S_ACK_A2;
      S_ACK_A2: if (byte_end) state_n = sda_smp ? S_STOP : S_RDATA;
      S_RDATA:  if (last_bit) state_n = S_MNACK;
      S_MNACK:  if (byte_end) state_n = S_STOP;
      S_STOP:   if (slot_end) state_n = S_IDLE;
      default:  state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK_100KHZ_IN or negedge RESET_N_IN) begin
    if (!RESET_N_IN) begin
      rw_q        <= RW_WRITE;
      dev_q       <= 7'd0;
      reg_q       <= 8'd0;
      wdata_q     <= 8'd0;
      rx_shift    <= 8'd0;
      sda_smp     <= 1'b0;
      RDATA_OUT   <= 8'd0;
      ACK_ERR_OUT <= 1'b0;
      DONE_OUT    <= 1'b0;
    end else begin
      DONE_OUT <= (state == S_STOP) && slot_end;

      if (state == S_IDLE && START_IN) begin
        rw_q        <= RW_IN;
        dev_q       <= DEV_ADDR_IN;
        reg_q       <= REG_ADDR_IN;
        wdata_q     <= WDATA_IN;
        ACK_ERR_OUT <= 1'b0;
      end

      if (sample_now) sda_smp <= SDA_IN;
      if (sample_now && state == S_RDATA) rx_shift <= {rx_shift[6:0], SDA_IN};
      // The eighth bit was shifted in at q2, so the full byte is ready here.
      if (last_bit && state == S_RDATA) RDATA_OUT <= rx_shift;
      if (byte_end && in_ack && sda_smp) ACK_ERR_OUT <= 1'b1;
    end
  end

  always_comb begin
    tx_byte = 8'hFF;
    case (state)
      S_ADDR_W: tx_byte = {dev_q, RW_WRITE};
      S_REG:    tx_byte = reg_q;
      S_WDATA:  tx_byte = wdata_q;
      S_ADDR_R: tx_byte = {dev_q, RW_READ};
      default:  tx_byte = 8'hFF;
    endcase
  end

  assign tx_bit = tx_byte[3'd7 - bit_cnt[2:0]];

  // Line levels per quarter-phase. SDA only moves in q0 (SCL low) for bit
  // slots; START, RSTART and STOP deliberately move it with SCL high.
  always_comb begin
    scl_lvl = 1'b1;
    sda_lvl = 1'b1;
    case (state)
      S_START: begin
        scl_lvl = (phase != 2'd3);
        sda_lvl = (phase < 2'd2);
      end
      S_RSTART: begin
        scl_lvl = mid_phase;
        sda_lvl = (phase < 2'd2);
      end
      S_STOP: begin
        scl_lvl = (phase != 2'd0);
        sda_lvl = (phase >= 2'd2);
      end
      S_ADDR_W, S_REG, S_WDATA, S_ADDR_R: begin
        scl_lvl = mid_phase;
        sda_lvl = tx_bit;
      end
      S_ACK_A, S_ACK_R, S_ACK_D, S_ACK_A2, S_RDATA, S_MNACK: begin
        scl_lvl = mid_phase;
        sda_lvl = 1'b1;
      end
      default: begin
        scl_lvl = 1'b1;
        sda_lvl = 1'b1;
      end
    endcase
  end

  assign SCL_OUT    = scl_lvl;
  assign SDA_OE_OUT = ~sda_lvl;

endmodule
